key_loader: RTL and testbench
=============================

# key_loader

Provisioning-side key delivery block for the logic-locked benchmark cores. It accepts a locking key as a serial bit stream over a valid/ready handshake, checks it with an even-parity bit, and presents it as a parallel key bus that feeds the `keyinputN` pins of a locked core. The key bus changes only after a load passes its parity check. An optional failed-attempt lockout is available.

## Interface
Parameters:
- `KEY_W`, default 4: key width in bits. Legal range is 1 to 64.
- `MAX_FAIL`, default 3: number of parity failures that triggers lockout. Used only when lockout is compiled in.

Ports:
- `clk`, input, 1 bit: the only clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `load_start`, input, 1 bit: single-cycle request to begin a key load.
- `sdata`, input, 1 bit: serial key or parity bit.
- `svalid`, input, 1 bit: `sdata` is valid this cycle.
- `sready`, output, 1 bit: the loader accepts `sdata` this cycle.
- `key_out`, output, `KEY_W` bits: the committed key, driven to the locked core's key inputs.
- `key_valid`, output, 1 bit: `key_out` holds a parity-checked key.
- `busy`, output, 1 bit: a load is in progress.
- `err`, output, 1 bit: one-cycle pulse when a load fails parity.
- `locked`, output, 1 bit: the loader is in permanent lockout until reset.

## Operation
States: IDLE, SHIFT, CHECK, and LOCKOUT (LOCKOUT exists only with the macro).

- **IDLE:**
  - `load_start` = 1 moves to SHIFT.
  - Clears `key_valid` and the bit counter.
  - `key_out` holds its previous value.
- **SHIFT:**
  - `sready` = 1.
  - A bit is accepted when `svalid && sready`.
  - Accepted bits fill the shadow register LSB first: accepted bit i goes to shadow[i] for i = 0 to `KEY_W`-1.
  - Accepted bit `KEY_W` is the parity bit.
  - After `KEY_W`+1 accepted bits, moves to CHECK.
  - Cycles with `svalid` = 0 are stalls with no state change. There is no timeout.
- **CHECK:** one cycle, `sready` = 0.
  - The check computes the XOR of the shadow bits and the parity bit.
  - Result 0 (pass): `key_out` ← shadow, `key_valid` ← 1, go to IDLE.
  - Result 1 (fail): `err` pulses, `key_out` and `key_valid` stay unchanged (`key_valid` remains 0), go to IDLE.
- **`busy`** = 1 in SHIFT and CHECK.
- **Ignored inputs:**
  - `load_start` is ignored in SHIFT, CHECK and LOCKOUT.
  - `svalid` is ignored outside SHIFT.
- **Reset mid-operation:** at any time, including mid-SHIFT, reset returns the block to IDLE and discards the shadow register.
- **Reset values:**
  - `key_out` = 0
  - `key_valid` = 0
  - `sready` = 0
  - `busy` = 0
  - `err` = 0
  - `locked` = 0
  - Bit counter = 0, fail counter = 0.
- **Counter widths:**
  - Bit counter is $clog2(`KEY_W`+2) bits wide and never wraps.
  - Fail counter is $clog2(`MAX_FAIL`+1) bits wide and saturates.

## Timing
- `load_start` sampled high on edge N puts the block in SHIFT during cycle N+1, with `sready` high.
- The minimum load, with `svalid` held high, accepts bits on edges N+1 through N+`KEY_W`+1. CHECK occupies the following cycle.
- `key_out`, `key_valid` and `err` update on the second rising edge after the last accepted bit.
- From `load_start`, minimum total latency to `key_valid` is `KEY_W`+3 edges.
- `load_start` on the same edge that CHECK returns to IDLE is ignored. A new load needs `load_start` asserted in an IDLE cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs, except that `sready` is derived from state only.

## Configuration
- Macro: `KEY_LOADER_LOCKOUT_EN`.
- **Defined:**
  - Each parity failure increments the fail counter.
  - When the counter reaches `MAX_FAIL`, the CHECK→IDLE transition goes to LOCKOUT instead.
  - In LOCKOUT: `locked` = 1, `key_out` = 0, `key_valid` = 0, `sready` = 0, `busy` = 0.
  - Only `rst_n` exits LOCKOUT.
  - A passing load clears the fail counter.
- **Not defined:** no fail counter, no LOCKOUT state, `locked` tied to 0, and parity failures are unlimited.

## Structure
- **Package `key_loader_pkg`** holds:
  - State enum `kl_state_t` (IDLE, SHIFT, CHECK, LOCKOUT).
  - `KL_PARITY_BITS` = 1.
- **Sub-module `key_shift_reg`** holds:
  - The `KEY_W` shadow register and parity accumulator.
  - Control inputs: shift-enable, bit-in, clear.
  - Outputs: shadow and `parity_ok`.
- The top level holds the FSM, the counters and the output registers.

## Test plan
All scenarios use `KEY_W` = 4 and `MAX_FAIL` = 3.
1. Key 4'hA: `load_start`, then continuous bits 0,1,0,1, parity 0 → `key_out` = 4'hA and `key_valid` = 1 exactly 7 edges after `load_start`; `err` never pulses.
2. Key 4'hA with `svalid` dropped for 3 cycles after bit 2 → same result, delayed by 3 edges; no bit is lost or duplicated.
3. Committed 4'hA, then load 4'h3 with bad parity 1 → `err` pulses one cycle, `key_out` stays 4'hA, `key_valid` = 0.
4. Reset asserted mid-SHIFT after 2 bits, then a clean load of 4'h5 → `key_out` = 4'h5; no residue of the aborted bits.
5. `load_start` pulsed during SHIFT and during CHECK → ignored; bit count and result are unaffected.
6. With `KEY_LOADER_LOCKOUT_EN`: three consecutive bad-parity loads → `locked` = 1 and `key_out` = 0; a later `load_start` plus a valid key leaves `sready` = 0; `rst_n` clears `locked`.

Source files
------------

// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared state encoding and constants for the key loader
package key_loader_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKOUT} kl_state_t;
  localparam int KL_PARITY_BITS = 1;
endpackage

// File: rtl/key_loader_if.sv
// key_loader_if: serial key stream in, parallel key bus and status out
// master drives load_start/sdata/svalid; slave (the loader) drives sready,
// key_out, key_valid, busy, err, locked.
interface key_loader_if #(parameter int KEY_W = 4);
  logic load_start;
  logic sdata;
  logic svalid;
  logic sready;
  logic [KEY_W-1:0] key_out;
  logic key_valid;
  logic busy;
  logic err;
  logic locked;
  modport master (output load_start, sdata, svalid, input sready, key_out, key_valid, busy, err, locked);
  modport slave (input load_start, sdata, svalid, output sready, key_out, key_valid, busy, err, locked);
endinterface

// File: rtl/key_shift_reg.sv
// key_shift_reg: LSB-first shadow register with running even-parity accumulator
// ports: clk, rst_n, en (shift one bit), din (bit in), clr (start of load),
// shadow (received key bits), parity_ok (key bits plus parity bit XOR to 0).
module key_shift_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic [KEY_W-1:0] shadow,
  output logic             parity_ok
);
  localparam int SW = KEY_W + KL_PARITY_BITS;
  // Right shift: after KEY_W+1 bits, bit 0 sits at sr[0] and parity at the top.
  logic [SW-1:0] sr;
  logic par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      par <= 1'b0;
    end else if (clr) begin
      sr <= '0;
      par <= 1'b0;
    end else if (en) begin
      sr <= {din, sr[SW-1:1]};
      par <= par ^ din;
    end
  end
  assign shadow = sr[KEY_W-1:0];
  assign parity_ok = !par;
endmodule

// File: rtl/key_loader.sv
// key_loader: serial key load with even-parity check onto a parallel key bus
// ports: clk, rst_n (async, active-low), bus (key_loader_if.slave).
// Optional lockout after MAX_FAIL parity failures: define KEY_LOADER_LOCKOUT_EN.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W    = 4,
  parameter int MAX_FAIL = 3
) (
  input  logic clk,
  input  logic rst_n,
  key_loader_if.slave bus
);
  localparam int CW = $clog2(KEY_W + 2);
  kl_state_t state;
  logic [CW-1:0] bit_cnt;
  logic [KEY_W-1:0] shadow;
  logic parity_ok, accept, start;
  // The check verdict is registered in CHECK and applied on the next edge.
  logic chk_pass, chk_fail;
`ifdef KEY_LOADER_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_cnt;
`else
  assign bus.locked = 1'b0;
`endif
  assign bus.sready = state == SHIFT;
  assign accept = bus.sready && bus.svalid;
  assign start = state == IDLE && bus.load_start;
  key_shift_reg #(.KEY_W(KEY_W)) u_shift (
    .clk(clk),
    .rst_n(rst_n),
    .en(accept),
    .din(bus.sdata),
    .clr(start),
    .shadow(shadow),
    .parity_ok(parity_ok)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      chk_pass <= 1'b0;
      chk_fail <= 1'b0;
      bus.key_out <= '0;
      bus.key_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
      fail_cnt <= '0;
      bus.locked <= 1'b0;
`endif
    end else begin
      chk_pass <= 1'b0;
      chk_fail <= 1'b0;
      bus.err <= chk_fail;
      if (chk_pass) begin
        bus.key_out <= shadow;
        bus.key_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (bus.load_start) begin
            state <= SHIFT;
            bus.busy <= 1'b1;
            bus.key_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.svalid) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(KEY_W)) state <= CHECK;
          end
        end
        CHECK: begin
          chk_pass <= parity_ok;
          chk_fail <= !parity_ok;
          state <= IDLE;
          bus.busy <= 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
          if (parity_ok) fail_cnt <= '0;
          else begin
            fail_cnt <= fail_cnt == FW'(MAX_FAIL) ? fail_cnt : fail_cnt + 1'b1;
            if (fail_cnt == FW'(MAX_FAIL - 1)) begin
              state <= LOCKOUT;
              bus.locked <= 1'b1;
              bus.key_out <= '0;
              bus.key_valid <= 1'b0;
            end
          end
`endif
        end
`ifdef KEY_LOADER_LOCKOUT_EN
        LOCKOUT: begin
          bus.key_out <= '0;
          bus.key_valid <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: table-driven and scoreboarded checks of key_loader (KEY_W=4, MAX_FAIL=3)
module tb_key_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [3:0] cur_key = 4'h0;
  key_loader_if #(.KEY_W(4)) bus ();
  key_loader #(.KEY_W(4), .MAX_FAIL(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int due;
    logic [3:0] key;
    logic valid, err, busy, locked;
  } ent_t;
  ent_t q[$];
  typedef struct {
    logic [3:0] k;
    logic p;
    int stall_at, stall_len;
    bit glitch;
    logic [3:0] ek;
    logic ev, ee;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due <= cyc) begin
      ent_t e;
      e = q.pop_front();
      chk("sb_due_cycle", cyc, e.due);
      chk("sb_key_out", bus.key_out, e.key);
      chk("sb_key_valid", bus.key_valid, e.valid);
      chk("sb_err", bus.err, e.err);
      chk("sb_busy", bus.busy, e.busy);
      chk("sb_locked", bus.locked, e.locked);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int due, input logic [3:0] key, input logic v, input logic e, input logic b, input logic l);
    ent_t x;
    x.due = due; x.key = key; x.valid = v; x.err = e; x.busy = b; x.locked = l;
    q.push_back(x);
  endtask
  task automatic run_load(input logic [3:0] k, input logic p, input int stall_at, input int stall_len,
                          input bit glitch, input logic [3:0] ek, input logic ev, input logic ee, input logic el);
    int base;
    base = cyc;
    push(base + 1, cur_key, 1'b0, 1'b0, 1'b1, 1'b0);
    push(base + 8 + stall_len, ek, ev, ee, 1'b0, el);
    push(base + 9 + stall_len, ek, ev, 1'b0, 1'b0, el);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sdata = i < 4 ? k[i] : p;
      bus.svalid = 1'b1;
      if (glitch && i == 1) bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      if (i == stall_at) begin
        bus.svalid = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          bus.sdata = 1'($urandom);
          tick();
        end
      end
    end
    bus.svalid = 1'b0;
    if (glitch) bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    repeat (3) tick();
    cur_key = ek;
  endtask
  task automatic chk_idle_reset(input string tag);
    chk({tag, "_key_out"}, bus.key_out, 4'h0);
    chk({tag, "_key_valid"}, bus.key_valid, 1'b0);
    chk({tag, "_sready"}, bus.sready, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_locked"}, bus.locked, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end
  initial begin
    vecs[0] = '{4'hA, 1'b0, -1, 0, 1'b0, 4'hA, 1'b1, 1'b0};
    vecs[1] = '{4'hA, 1'b0, 2, 3, 1'b0, 4'hA, 1'b1, 1'b0};
    vecs[2] = '{4'h3, 1'b1, -1, 0, 1'b0, 4'hA, 1'b0, 1'b1};
    vecs[3] = '{4'h5, 1'b0, -1, 0, 1'b1, 4'h5, 1'b1, 1'b0};
    vecs[4] = '{4'hF, 1'b0, 1, 2, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[5] = '{4'h7, 1'b1, -1, 0, 1'b1, 4'h7, 1'b1, 1'b0};
    vecs[6] = '{4'h9, 1'b0, 0, 1, 1'b0, 4'h9, 1'b1, 1'b0};
    vecs[7] = '{4'hE, 1'b0, -1, 0, 1'b0, 4'h9, 1'b0, 1'b1};
    bus.load_start = 1'b0;
    bus.sdata = 1'b0;
    bus.svalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset("reset");
    rst_n = 1'b1;
    tick();
    bus.svalid = 1'b1;
    tick();
    chk("svalid_in_idle_sready", bus.sready, 1'b0);
    chk("svalid_in_idle_busy", bus.busy, 1'b0);
    bus.svalid = 1'b0;
    foreach (vecs[i])
      run_load(vecs[i].k, vecs[i].p, vecs[i].stall_at, vecs[i].stall_len, vecs[i].glitch,
               vecs[i].ek, vecs[i].ev, vecs[i].ee, 1'b0);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.svalid = 1'b1;
    bus.sdata = 1'b1;
    repeat (2) tick();
    chk("midshift_sready", bus.sready, 1'b1);
    bus.svalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_reset("midshift_reset");
    tick();
    rst_n = 1'b1;
    cur_key = 4'h0;
    tick();
    run_load(4'h5, 1'b0, -1, 0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
    run_load(4'h3, 1'b1, -1, 0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    run_load(4'h3, 1'b1, -1, 0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
`ifdef KEY_LOADER_LOCKOUT_EN
    run_load(4'h3, 1'b1, -1, 0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.svalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.sdata = i[0];
      tick();
      chk("lockout_sready", bus.sready, 1'b0);
      chk("lockout_locked", bus.locked, 1'b1);
      chk("lockout_key_out", bus.key_out, 4'h0);
    end
    bus.svalid = 1'b0;
`else
    run_load(4'h3, 1'b1, -1, 0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    run_load(4'h6, 1'b0, -1, 0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0);
    chk("nolock_locked", bus.locked, 1'b0);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle_reset("final_reset");
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
